matrix_arbiter_hold: RTL



---
 rtl/matrix_arbiter_hold_if.sv | 22 ++
 rtl/matrix_arbiter_hold.sv | 84 ++++++++
 2 files changed

// File: rtl/matrix_arbiter_hold_if.sv
// Request/grant bundle between the switch-allocation requesters and the matrix arbiter.
interface matrix_arbiter_hold_if #(
  parameter int CHANNELS = 5,
  parameter int ID_W     = $clog2(CHANNELS)
);
  logic [CHANNELS-1:0] request_vector;
  logic [CHANNELS-1:0] release_vector;
  logic                ready;
  logic [CHANNELS-1:0] grant_vector;
  logic                grant_valid;
  logic [ID_W-1:0]     grant_id;

  modport master (
    output request_vector, release_vector, ready,
    input  grant_vector, grant_valid, grant_id
  );

  modport slave (
    input  request_vector, release_vector, ready,
    output grant_vector, grant_valid, grant_id
  );
endinterface

// File: rtl/matrix_arbiter_hold.sv
// Least-recently-granted matrix arbiter with registered grant and optional
// packet lock that is held until the owner's tail flit transfers.
module matrix_arbiter_hold #(
  parameter int CHANNELS = 5,
  parameter bit HOLD_EN  = 1'b1,
  parameter int ID_W     = $clog2(CHANNELS)
) (
  input logic                  CLK,
  input logic                  RST,
  matrix_arbiter_hold_if.slave bus
);

  localparam int NPAIR = CHANNELS * (CHANNELS - 1) / 2;

  // Upper triangle packed row by row; bit set means the lower index of the pair wins.
  function automatic int pair_idx(input int i, input int j);
    return i * CHANNELS - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [NPAIR-1:0]                   prio_q;
  logic [NPAIR-1:0]                   prio_d;
  logic [CHANNELS-1:0][CHANNELS-1:0]  beats;
  logic [CHANNELS-1:0]                winner;
  logic [CHANNELS-1:0]                grant_q;
  logic [ID_W-1:0]                    id_q;
  logic [ID_W-1:0]                    id_d;
  logic                               valid;
  logic                               owner_req;
  logic                               owner_rel;
  logic                               xfer;
  logic                               finish;
  logic                               free;
  logic                               load;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_row
    for (genvar j = 0; j < CHANNELS; j++) begin : g_col
      if (i == j) begin : g_diag
        assign beats[i][j] = 1'b1;
      end else if (i < j) begin : g_upper
        localparam int K = pair_idx(i, j);
        assign beats[i][j] = prio_q[K];
        assign prio_d[K]   = winner[i] ? 1'b0 : (winner[j] ? 1'b1 : prio_q[K]);
      end else begin : g_lower
        assign beats[i][j] = ~prio_q[pair_idx(j, i)];
      end
    end
    // Non-requesters are masked out so only requesting rivals are compared.
    assign winner[i] = bus.request_vector[i] & (&(beats[i] | ~bus.request_vector));
  end

  assign valid     = |grant_q;
  assign owner_req = |(grant_q & bus.request_vector);
  assign owner_rel = |(grant_q & bus.release_vector);
  assign xfer      = valid & owner_req & bus.ready;
  assign finish    = (xfer & (owner_rel | ~HOLD_EN)) | (valid & ~owner_req);
  assign free      = ~valid | finish;
  assign load      = free & (|bus.request_vector);

  always_comb begin
    id_d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (winner[k]) id_d = k[ID_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_q <= '0;
      id_q    <= '0;
      prio_q  <= '1;
    end else begin
      if (free) begin
        grant_q <= winner;
        id_q    <= id_d;
      end
      if (load) prio_q <= prio_d;
    end
  end

  assign bus.grant_vector = grant_q;
  assign bus.grant_valid  = valid;
  assign bus.grant_id     = id_q;

endmodule
